udma_hyper_ch_arbiter: RTL and testbench



---
 rtl/udma_hyper_pkg.sv | 13 +
 rtl/udma_hyper_rr_pick.sv | 35 +++
 rtl/udma_hyper_ch_arbiter.sv | 147 ++++++++++++++
 tb/tb_udma_hyper_ch_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_hyper_pkg.sv
// Shared types and helpers for the HyperBus uDMA channel scheduling logic.
package udma_hyper_pkg;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_OFFER = 1'b1} hyper_arb_state_e;

    localparam int unsigned HYPER_MASK_W = 32;

    // IDs at or beyond HYPER_MASK_W yield an all-zero mask.
    function automatic logic [HYPER_MASK_W-1:0] hyper_id_to_onehot(input int unsigned id);
        return HYPER_MASK_W'(1) << id;
    endfunction

endpackage

// File: rtl/udma_hyper_rr_pick.sv
// Combinational round-robin picker: rotate the eligible vector down by the start pointer,
// priority-encode the lowest set bit, then map the offset back to a channel index.
module udma_hyper_rr_pick #(
    parameter int unsigned NB_CH = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NB_CH-1:0] eligible_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*NB_CH-1:0] doubled;
    logic [NB_CH-1:0]   rotated;
    int unsigned        offs;
    int unsigned        sum;

    always_comb begin
        doubled = {eligible_i, eligible_i} >> start_i;
        rotated = doubled[NB_CH-1:0];
        found_o = |rotated;
        offs    = 0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offs = i;
            end
        end
        sum = 32'(start_i) + offs;
        if (sum >= NB_CH) begin
            sum = sum - NB_CH;
        end
        idx_o = IDX_W'(sum);
    end

endmodule

// File: rtl/udma_hyper_ch_arbiter.sv
// Schedules uDMA channel requests onto the single HyperBus PHY transaction port.
// Define UDMA_HYPER_ARB_FIXED_PRIO_EN for fixed priority (lowest index) instead of round-robin.
module udma_hyper_ch_arbiter
    import udma_hyper_pkg::*;
#(
    parameter int unsigned ID_WIDTH        = 1,
    parameter int unsigned NB_CH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NB_CH-1:0]    ch_req_i,
    output logic [NB_CH-1:0]    ch_gnt_o,
    input  logic [NB_CH-1:0]    phy_busy_vec_i,
    output logic                trans_valid_o,
    input  logic                trans_ready_i,
    output logic [ID_WIDTH:0]   trans_id_o,
    input  logic                done_valid_i,
    input  logic [ID_WIDTH:0]   done_id_i,
    output logic [NB_CH-1:0]    inflight_vec_o,
    output logic [OUT_W-1:0]    outstanding_o
);

    localparam int unsigned IDW = ID_WIDTH + 1;

    hyper_arb_state_e state_q, state_d;
    logic             trans_valid_q, trans_valid_d;
    logic [IDW-1:0]   trans_id_q, trans_id_d;
    logic [NB_CH-1:0] inflight_q, inflight_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;

    logic [NB_CH-1:0] eligible;
    logic [NB_CH-1:0] id_mask;
    logic [NB_CH-1:0] done_mask;
    logic [IDW-1:0]   rr_ptr;
    logic             accept;
    logic             pick_found;
    logic [IDW-1:0]   pick_idx;

    // Registered inflight mask: a channel freed this cycle becomes eligible next cycle.
    assign eligible = ch_req_i & ~phy_busy_vec_i & ~inflight_q;
    assign accept   = rst_ni & trans_valid_q & trans_ready_i;

    always_comb begin
        id_mask   = NB_CH'(hyper_id_to_onehot(32'(trans_id_q)));
        done_mask = '0;
        if (done_valid_i) begin
            done_mask = NB_CH'(hyper_id_to_onehot(32'(done_id_i))) & inflight_q;
        end
    end

    assign ch_gnt_o = accept ? id_mask : '0;

    udma_hyper_rr_pick #(
        .NB_CH (NB_CH),
        .IDX_W (IDW)
    ) u_pick (
        .eligible_i (eligible),
        .start_i    (rr_ptr),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

`ifdef UDMA_HYPER_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (trans_id_q == IDW'(NB_CH - 1)) ? '0 : trans_id_q + IDW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    always_comb begin
        inflight_d    = (inflight_q & ~done_mask) | (accept ? id_mask : '0);
        outstanding_d = '0;
        for (int i = 0; i < NB_CH; i++) begin
            outstanding_d = outstanding_d + OUT_W'(inflight_d[i]);
        end
    end

    always_comb begin
        state_d       = state_q;
        trans_valid_d = trans_valid_q;
        trans_id_d    = trans_id_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found && (outstanding_q < OUT_W'(MAX_OUTSTANDING))) begin
                    trans_id_d    = pick_idx;
                    trans_valid_d = 1'b1;
                    state_d       = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                // The offer is held until accepted, regardless of request/busy changes.
                if (accept) begin
                    trans_valid_d = 1'b0;
                    state_d       = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ARB_IDLE;
            trans_valid_q <= 1'b0;
            trans_id_q    <= '0;
            inflight_q    <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            trans_valid_q <= trans_valid_d;
            trans_id_q    <= trans_id_d;
            inflight_q    <= inflight_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (outstanding_q <= OUT_W'(MAX_OUTSTANDING));
            assert (!((|done_mask) && (outstanding_q == '0)));
        end
    end

    assign trans_valid_o  = trans_valid_q;
    assign trans_id_o     = trans_id_q;
    assign inflight_vec_o = inflight_q;
    assign outstanding_o  = outstanding_q;

endmodule

// File: tb/tb_udma_hyper_ch_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-free
// behavioural model of the scheduler.
module tb_udma_hyper_ch_arbiter;

    localparam int unsigned NB   = 2;
    localparam int unsigned MAXO = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, busy, gnt, inflight;
    logic       ready, valid, done_v;
    logic [1:0] tid, done_id, outst;

    logic       rst_b;
    logic [1:0] req_b, busy_b, gnt_b, inflight_b;
    logic       ready_b, valid_b, done_v_b;
    logic [1:0] tid_b, done_id_b;
    logic [0:0] outst_b;

    int total = 0;
    int bad   = 0;

    bit         m_valid;
    int         m_id;
    bit [NB-1:0] m_inflight;
    int         m_ptr;
    logic [1:0] obs_gnt;

    always #5 clk = ~clk;

    udma_hyper_ch_arbiter #(
        .ID_WIDTH        (1),
        .NB_CH           (NB),
        .MAX_OUTSTANDING (MAXO)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ch_req_i       (req),
        .ch_gnt_o       (gnt),
        .phy_busy_vec_i (busy),
        .trans_valid_o  (valid),
        .trans_ready_i  (ready),
        .trans_id_o     (tid),
        .done_valid_i   (done_v),
        .done_id_i      (done_id),
        .inflight_vec_o (inflight),
        .outstanding_o  (outst)
    );

    udma_hyper_ch_arbiter #(
        .ID_WIDTH        (1),
        .NB_CH           (2),
        .MAX_OUTSTANDING (1)
    ) u_dut_max1 (
        .clk_i          (clk),
        .rst_ni         (rst_b),
        .ch_req_i       (req_b),
        .ch_gnt_o       (gnt_b),
        .phy_busy_vec_i (busy_b),
        .trans_valid_o  (valid_b),
        .trans_ready_i  (ready_b),
        .trans_id_o     (tid_b),
        .done_valid_i   (done_v_b),
        .done_id_i      (done_id_b),
        .inflight_vec_o (inflight_b),
        .outstanding_o  (outst_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the reference: check the combinational grant, advance the model by the
    // scheduling rules, then check the registered outputs after the edge.
    task automatic cycle();
        bit [NB-1:0] elig;
        bit [NB-1:0] exp_gnt;
        int          cnt;
        int          idx;
        #1;
        exp_gnt = '0;
        if (rst_n && m_valid && ready) exp_gnt[m_id] = 1'b1;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        obs_gnt = gnt;
        if (!rst_n) begin
            m_valid    = 0;
            m_id       = 0;
            m_inflight = '0;
            m_ptr      = 0;
        end else begin
            elig = req & ~busy & ~m_inflight;
            cnt  = $countones(m_inflight);
            if (done_v && (int'(done_id) < NB) && m_inflight[done_id]) m_inflight[done_id] = 1'b0;
            if (m_valid) begin
                if (ready) begin
                    m_inflight[m_id] = 1'b1;
                    m_ptr   = (m_id + 1) % NB;
                    m_valid = 0;
                end
            end else if ((elig != 0) && (cnt < MAXO)) begin
`ifdef UDMA_HYPER_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`endif
                for (int k = NB - 1; k >= 0; k--) begin
                    idx = (m_ptr + k) % NB;
                    if (elig[idx]) m_id = idx;
                end
                m_valid = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 32'(valid), 32'(m_valid));
        chk("id", 32'(tid), 32'(m_id));
        chk("inflight", 32'(inflight), 32'(m_inflight));
        chk("outstanding", 32'(outst), 32'($countones(m_inflight)));
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        busy   = '0;
        ready  = 1'b0;
        done_v = 1'b0;
        cycle();
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; busy = '0; ready = 1'b0; done_v = 1'b0; done_id = '0;
        rst_b = 1'b0; req_b = '0; busy_b = '0; ready_b = 1'b0; done_v_b = 1'b0; done_id_b = '0;
        m_valid = 0; m_id = 0; m_inflight = '0; m_ptr = 0;

        do_reset();
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_out", 32'(outst), 32'(0));

        // Both channels requesting: grants two cycles apart.
        req = 2'b11; ready = 1'b1;
        cycle();
        chk("t1_valid", 32'(valid), 32'(1));
        cycle();
        chk("t1_gnt_a", 32'(obs_gnt), 32'(2'b01));
        chk("t1_out_a", 32'(outst), 32'(1));
        cycle();
        chk("t1_gap", 32'(obs_gnt), 32'(0));
        cycle();
        chk("t1_gnt_b", 32'(obs_gnt), 32'(2'b10));
        chk("t1_out_b", 32'(outst), 32'(2));

        // Offer held while ready is low, even after the request drops.
        do_reset();
        req = 2'b01; ready = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req = 2'b00;
            cycle();
            chk("t2_hold_valid", 32'(valid), 32'(1));
            chk("t2_hold_id", 32'(tid), 32'(0));
        end
        ready = 1'b1;
        cycle();
        chk("t2_gnt", 32'(obs_gnt), 32'(2'b01));

        // Completion of ch0 in the same cycle ch1 is accepted.
        req = 2'b10;
        cycle();
        done_v = 1'b1; done_id = 2'd0;
        cycle();
        done_v = 1'b0;
        chk("t3_gnt", 32'(obs_gnt), 32'(2'b10));
        chk("t3_inflight", 32'(inflight), 32'(2'b10));
        chk("t3_out", 32'(outst), 32'(1));

        // Busy channel skipped; out-of-range done ignored.
        do_reset();
        busy = 2'b01; req = 2'b11; ready = 1'b0;
        cycle();
        chk("t4_id", 32'(tid), 32'(1));
        done_v = 1'b1; done_id = 2'd3;
        cycle();
        done_v = 1'b0;
        chk("t4_inflight", 32'(inflight), 32'(0));
        chk("t4_out", 32'(outst), 32'(0));
        chk("t4_valid", 32'(valid), 32'(1));

        // Reset in the middle of an offer clears everything including the pointer.
        do_reset();
        req = 2'b11; ready = 1'b1;
        cycle();
        cycle();
        ready = 1'b0;
        cycle();
        chk("t6_pre_id", 32'(tid), 32'(1));
        rst_n = 1'b0;
        cycle();
        chk("t6_valid", 32'(valid), 32'(0));
        chk("t6_inflight", 32'(inflight), 32'(0));
        chk("t6_out", 32'(outst), 32'(0));
        rst_n = 1'b1;
        cycle();
        chk("t6_ptr", 32'(tid), 32'(0));

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            req     = 2'($urandom);
            busy    = 2'($urandom & $urandom);
            ready   = ($urandom_range(0, 2) != 0);
            done_v  = ($urandom_range(0, 2) == 0);
            done_id = 2'($urandom_range(0, 3));
            cycle();
        end
        rst_n = 1'b1; done_v = 1'b0;

        // MAX_OUTSTANDING=1: ch1 waits until ch0 completes.
        @(posedge clk); #1;
        rst_b = 1'b1; req_b = 2'b01; ready_b = 1'b1;
        @(posedge clk); #1;
        chk("t5_valid0", 32'(valid_b), 32'(1));
        chk("t5_gnt0", 32'(gnt_b), 32'(2'b01));
        @(posedge clk); #1;
        chk("t5_out1", 32'(outst_b), 32'(1));
        req_b = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t5_blocked", 32'(valid_b), 32'(0));
        end
        done_v_b = 1'b1; done_id_b = 2'd0;
        @(posedge clk); #1;
        done_v_b = 1'b0;
        chk("t5_freed_valid", 32'(valid_b), 32'(0));
        chk("t5_freed_out", 32'(outst_b), 32'(0));
        @(posedge clk); #1;
        chk("t5_valid1", 32'(valid_b), 32'(1));
        chk("t5_id1", 32'(tid_b), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
